// File: rtl/seq_stepper.sv
// Pushbutton sequence selector and step sequencer; button/tick effects land on the 3rd clk_50 edge after the input rises.
// Optional DEBOUNCE_EN adds a DB_CYCLES stability filter on both buttons (latency 3+DB_CYCLES); no backpressure.
module seq_stepper #(
  parameter int NUM_SEQ       = 8,
  parameter int SEQ_W         = 3,
  parameter int STEPS_PER_SEQ = 16,
  parameter int STEP_W        = 4,
  parameter int LED_W         = 8,
  parameter int WRAP_SEQ      = 1
`ifdef DEBOUNCE_EN
  , parameter int DB_CYCLES   = 500000
`endif
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic                    pb_seq_up,
  input  logic                    pb_seq_dn,
  input  logic                    slow_clk,
  input  logic                    run_en,
  output logic [SEQ_W+STEP_W-1:0] ROM_addr,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [STEP_W-1:0]       step_num,
  output logic [LED_W-1:0]        LEDS,
  output logic                    seq_done
);

  typedef enum logic {ST_PAUSE = 1'b0, ST_PLAY = 1'b1} state_t;

  localparam logic [SEQ_W-1:0]  LP_SEQ_MAX  = SEQ_W'(NUM_SEQ - 1);
  localparam logic [STEP_W-1:0] LP_STEP_MAX = STEP_W'(STEPS_PER_SEQ - 1);
  localparam int                LP_LIDX_W   = (LED_W > 1) ? $clog2(LED_W) : 1;

  // Bit 0 = up button, bit 1 = down button, bit 2 = step tick.
  logic [2:0] w_raw;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_prev;
  logic [2:0] r_arm;
  logic [2:0] w_lvl;
  logic [2:0] w_ev;
  logic [1:0] r_fill;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_play;
  logic   w_show_step;

  logic [SEQ_W-1:0]     r_seq;
  logic [STEP_W-1:0]    r_step;
  logic [LED_W-1:0]     r_leds;
  logic                 r_done;
  logic [SEQ_W-1:0]     w_seq_nxt;
  logic                 w_seq_chg;
  logic [STEP_W-1:0]    w_step_nxt;
  logic                 w_done_nxt;
  logic [LP_LIDX_W-1:0] w_led_idx;
  logic [LED_W-1:0]     w_led_nxt;

  assign w_raw = {slow_clk, pb_seq_dn, pb_seq_up};

  // An input only becomes armed once it has been seen low through a fully
  // refilled synchroniser, so a level held across reset never fires.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_arm  <= '0;
      r_fill <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_prev <= w_lvl;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1]) begin
        r_arm <= r_arm | ~r_s2;
      end
    end
  end

`ifdef DEBOUNCE_EN
  localparam int                 LP_DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [LP_DB_W-1:0] LP_DB_LAST = LP_DB_W'(DB_CYCLES - 1);

  logic [1:0]         r_db;
  logic [LP_DB_W-1:0] r_db_cnt [2];

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_db <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == LP_DB_LAST) begin
          r_db[i]     <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = {r_s2[2], r_db};
`else
  assign w_lvl = r_s2;
`endif

  assign w_ev = w_lvl & ~r_prev & r_arm;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state <= ST_PAUSE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (run_en) begin
      w_state_nxt = ST_PLAY;
    end else begin
      w_state_nxt = ST_PAUSE;
    end
  end

  always_comb begin
    w_play      = (r_state == ST_PLAY);
    w_show_step = (w_state_nxt == ST_PLAY);
  end

  always_comb begin
    w_seq_nxt = r_seq;
    if (w_ev[0] && !w_ev[1]) begin
      if (r_seq == LP_SEQ_MAX) begin
        w_seq_nxt = (WRAP_SEQ != 0) ? '0 : r_seq;
      end else begin
        w_seq_nxt = r_seq + 1'b1;
      end
    end else if (w_ev[1] && !w_ev[0]) begin
      if (r_seq == '0) begin
        w_seq_nxt = (WRAP_SEQ != 0) ? LP_SEQ_MAX : r_seq;
      end else begin
        w_seq_nxt = r_seq - 1'b1;
      end
    end
    w_seq_chg = (w_seq_nxt != r_seq);

    // A real sequence change overrides a coincident tick.
    w_step_nxt = r_step;
    w_done_nxt = 1'b0;
    if (w_seq_chg) begin
      w_step_nxt = '0;
    end else if (w_play && w_ev[2]) begin
      if (r_step == LP_STEP_MAX) begin
        w_step_nxt = '0;
        w_done_nxt = 1'b1;
      end else begin
        w_step_nxt = r_step + 1'b1;
      end
    end

    w_led_idx = LP_LIDX_W'(32'(w_step_nxt) % LED_W);
    w_led_nxt = '0;
    if (w_show_step) begin
      w_led_nxt[w_led_idx] = 1'b1;
    end else begin
      w_led_nxt = LED_W'(w_seq_nxt);
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_seq  <= '0;
      r_step <= '0;
      r_leds <= '0;
      r_done <= 1'b0;
    end else begin
      r_seq  <= w_seq_nxt;
      r_step <= w_step_nxt;
      r_leds <= w_led_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign ROM_addr = {r_seq, r_step};
  assign seq_num  = r_seq;
  assign step_num = r_step;
  assign LEDS     = r_leds;
  assign seq_done = r_done;

endmodule
